// File: rtl/rv_pkg.sv
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared constants and state encoding for the multi-port
//                register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int BYTE_W       = 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ============================================================================
//  Module      : regfile_rdport
//  Description : One registered read port with write-bypass byte merge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rdport
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int AW   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_run,
    input  logic                   i_rd_en,
    input  logic [AW-1:0]          i_rs_addr,
    input  logic [XLEN-1:0]        i_old_data,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [XLEN-1:0]        i_wr_data,
    input  logic [XLEN/BYTE_W-1:0] i_wr_be,
    output logic [XLEN-1:0]        o_rs_data
);

    localparam int c_nbytes = XLEN / BYTE_W;

    logic [XLEN-1:0] w_merged;
    logic            w_hit;
    logic [XLEN-1:0] r_data;

    for (genvar b = 0; b < c_nbytes; b++) begin : g_byte
        assign w_merged[b*BYTE_W +: BYTE_W] = i_wr_be[b] ? i_wr_data[b*BYTE_W +: BYTE_W]
                                                          : i_old_data[b*BYTE_W +: BYTE_W];
    end

    // Register 0 is hardwired, so a write to it never bypasses.
    assign w_hit = i_we && (i_rs_addr == i_wr_addr) && (i_rs_addr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (!i_run) begin
            r_data <= '0;
        end else if (i_rd_en) begin
            r_data <= w_hit ? w_merged : i_old_data;
        end
    end

    assign o_rs_data = i_run ? r_data : '0;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-read-port register file with byte-enabled writes and
//                a self-zeroing clear pass after reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_req,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*AW-1:0]      rs_addr,
    output logic [NRD*XLEN-1:0]    rs_data,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [XLEN/BYTE_W-1:0] wr_be,
    output logic                   ready
);

    localparam int            c_nbytes    = XLEN / BYTE_W;
    localparam logic [AW-1:0] c_last_addr = AW'(NREG - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;
    logic            w_run;
    logic            w_wr_fire;
    logic [XLEN-1:0] r_regs [NREG];

    assign w_run     = (r_state == ST_RUN);
    assign w_wr_fire = w_run && we && (wr_addr != '0);
    assign ready     = w_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                if (clear_req) begin
                    w_clr_cnt_nxt = '0;
                end else if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                end
            end
        endcase
    end

    // Storage is zeroed only by the clear pass, never by reset.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_regs[r_clr_cnt] <= '0;
        end else if (w_wr_fire) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (wr_be[b]) begin
                    r_regs[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rdport
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_old;

        assign w_addr = rs_addr[k*AW +: AW];
        assign w_old  = (w_addr == '0) ? '0 : r_regs[w_addr];

        regfile_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rdport (
            .clk        (clk),
            .rst        (reset),
            .i_run      (w_run),
            .i_rd_en    (rd_en[k]),
            .i_rs_addr  (w_addr),
            .i_old_data (w_old),
            .i_we       (we),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .i_wr_be    (wr_be),
            .o_rs_data  (rs_data[k*XLEN +: XLEN])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp (table, corner sequences,
//                randomized traffic against an array-based reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int NB   = XLEN / 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                clear_req;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic                we;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic [NB-1:0]       wr_be;
    logic                ready;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .rd_en     (rd_en),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .ready     (ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain array, cycles left in the clear pass, expected outputs.
    logic [XLEN-1:0] m_mem [NREG];
    logic [XLEN-1:0] m_out [NRD];
    int              m_left;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [31:0]   wd;
        logic [NB-1:0] be;
        logic [1:0]    rden;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [31:0]   e0;
        logic [31:0]   e1;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_v,
                                              input logic [XLEN-1:0] new_v,
                                              input logic [NB-1:0] be);
        logic [XLEN-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = NREG;
        for (int k = 0; k < NRD; k++) m_out[k] = '0;
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge(input logic c_clr, input logic c_we, input logic [AW-1:0] c_wa,
                              input logic [XLEN-1:0] c_wd, input logic [NB-1:0] c_be,
                              input logic [NRD-1:0] c_rden, input logic [NRD*AW-1:0] c_ra);
        logic [AW-1:0] a;
        if (m_left == 0) begin
            for (int k = 0; k < NRD; k++) begin
                if (c_rden[k]) begin
                    a = c_ra[k*AW +: AW];
                    if (a == 0) m_out[k] = '0;
                    else if (c_we && a == c_wa) m_out[k] = merge(m_mem[a], c_wd, c_be);
                    else m_out[k] = m_mem[a];
                end
            end
            if (c_we && c_wa != 0) m_mem[c_wa] = merge(m_mem[c_wa], c_wd, c_be);
            if (c_clr) model_reset();
        end else begin
            if (c_clr) m_left = NREG;
            else m_left--;
            for (int k = 0; k < NRD; k++) m_out[k] = '0;
        end
    endtask

    task automatic compare_all();
        check("ready", {31'b0, ready}, {31'b0, (m_left == 0)});
        for (int k = 0; k < NRD; k++)
            check($sformatf("rs_data%0d", k), rs_data[k*XLEN +: XLEN], m_out[k]);
    endtask

    task automatic tick();
        logic c_clr, c_we;
        logic [AW-1:0] c_wa;
        logic [XLEN-1:0] c_wd;
        logic [NB-1:0] c_be;
        logic [NRD-1:0] c_rden;
        logic [NRD*AW-1:0] c_ra;
        c_clr = clear_req; c_we = we; c_wa = wr_addr; c_wd = wr_data;
        c_be = wr_be; c_rden = rd_en; c_ra = rs_addr;
        @(posedge clk);
        model_edge(c_clr, c_we, c_wa, c_wd, c_be, c_rden, c_ra);
        #1;
        compare_all();
    endtask

    task automatic idle();
        clear_req = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = '0; rs_addr = '0;
    endtask

    task automatic wait_ready(input string name);
        int cycles;
        cycles = 0;
        while (!ready && cycles < 200) begin
            tick();
            cycles++;
        end
        check(name, cycles, 32);
    endtask

    // Asserts reset mid-cycle, checks the immediate effect, then releases it.
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        check({name, "_rs0"}, rs_data[31:0], 32'h0);
        check({name, "_rs1"}, rs_data[63:32], 32'h0);
        check({name, "_ready"}, {31'b0, ready}, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd5, 32'h11223344, 4'b0101, 2'b11, 5'd5, 5'd5, 32'hDE22BE44, 32'hDE22BE44};
        tbl[3] = '{1'b0, 5'd0, 32'h0, 4'h0, 2'b11, 5'd5, 5'd1, 32'hDE22BE44, 32'h0};
        tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 5'd0, 32'h0, 4'h0, 2'b01, 5'd0, 5'd0, 32'h0, 32'h0};
        tbl[6] = '{1'b1, 5'd9, 32'hA5A5A5A5, 4'b1000, 2'b10, 5'd0, 5'd9, 32'h0, 32'hA5000000};
        tbl[7] = '{1'b0, 5'd0, 32'h0, 4'h0, 2'b01, 5'd9, 5'd0, 32'hA5000000, 32'hA5000000};
        tbl[8] = '{1'b1, 5'd9, 32'h000000FF, 4'b0001, 2'b11, 5'd9, 5'd5, 32'hA50000FF, 32'hDE22BE44};

        idle();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rs0", rs_data[31:0], 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);
        reset = 1'b0;
        wait_ready("clear_len_after_reset");

        for (int i = 1; i < NREG; i++) begin
            rd_en = 2'b11;
            rs_addr = {AW'(NREG - i), AW'(i)};
            tick();
            check("zero_after_clear", rs_data[31:0], 32'h0);
        end

        for (int v = 0; v < 9; v++) begin
            we = tbl[v].we; wr_addr = tbl[v].wa; wr_data = tbl[v].wd; wr_be = tbl[v].be;
            rd_en = tbl[v].rden; rs_addr = {tbl[v].ra1, tbl[v].ra0};
            tick();
            check($sformatf("tbl%0d_p0", v), rs_data[31:0], tbl[v].e0);
            check($sformatf("tbl%0d_p1", v), rs_data[63:32], tbl[v].e1);
        end
        idle();

        // clear request with a same-cycle write, then writes during the clear pass
        clear_req = 1'b1; we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1; wr_be = 4'hF;
        tick();
        check("clear_req_ready_drop", {31'b0, ready}, 32'h0);
        clear_req = 1'b0; wr_data = 32'hFFFFFFFF; rd_en = 2'b11; rs_addr = {5'd7, 5'd7};
        wait_ready("clear_req_len");
        idle();
        rd_en = 2'b01; rs_addr = {5'd0, 5'd7};
        tick();
        check("x7_after_clear", rs_data[31:0], 32'h0);
        idle();

        // asynchronous reset while running with live read data
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        tick();
        idle();
        rd_en = 2'b11; rs_addr = {5'd3, 5'd3};
        tick();
        check("x3_before_reset", rs_data[31:0], 32'hCAFEF00D);
        idle();
        do_reset("run_reset");
        wait_ready("clear_len_after_run_reset");

        // reset at clear count 10
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        do_reset("midclear_reset");
        wait_ready("clear_len_after_midclear_reset");

        // clear request while already clearing restarts the count
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (5) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_ready("clear_restart_len");

        for (int n = 0; n < 800; n++) begin
            clear_req = ($urandom_range(0, 149) == 0);
            we = $urandom_range(0, 1) == 1;
            wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
            wr_data = $urandom;
            wr_be = NB'($urandom_range(0, 15));
            rd_en = NRD'($urandom_range(0, 3));
            rs_addr[AW-1:0] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
            rs_addr[2*AW-1:AW] = ($urandom_range(0, 1) == 1) ? rs_addr[AW-1:0] : AW'($urandom_range(0, NREG - 1));
            tick();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
